// File: rtl/turbo_pkg.sv
// Shared definitions for the QPP turbo encoder: FSM states, RSC
// polynomials and block-length limits.
package turbo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ENC,
    ST_TAIL1,
    ST_TAIL2
  } state_e;

  // Polynomial taps, bit i is the coefficient of D^i.
  // Feedback 1 + D^2 + D^3, parity 1 + D + D^3.
  localparam logic [3:0] RSC_FB_POLY  = 4'b1101;
  localparam logic [3:0] RSC_PAR_POLY = 4'b1011;

  // Termination beats per constituent encoder.
  localparam int TAIL_LEN = 3;

  // Smallest legal block length.
  localparam int MIN_K = 40;

endpackage

// File: rtl/turbo_rsc.sv
// Recursive systematic convolutional constituent encoder (8 states).
// When term is set, the input is replaced by the feedback taps so the
// register is flushed to zero in three enabled steps.
module turbo_rsc
  import turbo_pkg::*;
(
  input  logic       clock,
  input  logic       resetb,
  input  logic       clr,
  input  logic       en,
  input  logic       term,
  input  logic       u,
  output logic       z,
  output logic       x,
  output logic [2:0] state
);

  // s_q[0] = s1, s_q[1] = s2, s_q[2] = s3
  logic [2:0] s_q;
  logic       fb_taps;
  logic       a;

  assign fb_taps = (RSC_FB_POLY[1] & s_q[0]) ^ (RSC_FB_POLY[2] & s_q[1]) ^
                   (RSC_FB_POLY[3] & s_q[2]);
  // During termination the systematic bit equals the feedback, forcing a = 0.
  assign x       = term ? fb_taps : u;
  assign a       = x ^ fb_taps;
  assign z       = (RSC_PAR_POLY[0] & a)      ^ (RSC_PAR_POLY[1] & s_q[0]) ^
                   (RSC_PAR_POLY[2] & s_q[1]) ^ (RSC_PAR_POLY[3] & s_q[2]);
  assign state   = {s_q[0], s_q[1], s_q[2]};

  // Shift register advance: (s1, s2, s3) <= (a, s1, s2).
  always_ff @(posedge clock or negedge resetb) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!resetb) begin
      s_q <= 3'b000;
    end else if (clr) begin
      s_q <= 3'b000;
    end else if (en) begin
      s_q <= {s_q[1:0], a};
    end
  end

endmodule

// File: rtl/turbo_encoder_qpp.sv
// LTE-style rate-1/3 turbo encoder with a quadratic permutation
// polynomial interleaver. A block of K bits is buffered, then streamed
// out as K beats of {sys, par1, par2} followed by six tail beats.
module turbo_encoder_qpp
  import turbo_pkg::*;
#(
  parameter int K_MAX = 256,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic [KW-1:0] f1,
  input  logic [KW-1:0] f2,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_data,
  output logic          out_tail,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

  // (a + b) mod m for a, b < m, widened by one bit so the sum cannot wrap.
  function automatic logic [KW-1:0] mod_add(input logic [KW-1:0] a,
                                            input logic [KW-1:0] b,
                                            input logic [KW-1:0] m);
    logic [KW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[KW-1:0];
  endfunction

  state_e          state_q;
  logic [KW-1:0]   cnt_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   g0_q;
  logic [KW-1:0]   d_q;
  logic [KW-1:0]   pi_q;
  logic [KW-1:0]   g_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [2:0]      out_data_q;
  logic            out_tail_q;
  logic            busy_q;
  logic            done_q;
  logic            cfg_err_q;
  logic [K_MAX-1:0] mem_q;

  logic            cfg_ok;
  logic            start_ok;
  logic            load_fire;
  logic            out_fire;
  logic            slot_free;
  logic            gen_enc;
  logic            gen_t1;
  logic            gen_t2;
  logic            gen;
  logic            u1;
  logic            u2;
  logic            z1;
  logic            z2;
  logic            x1;
  logic            x2;
  logic [2:0]      rsc1_state;
  logic [2:0]      rsc2_state;
  logic            rsc_state_unused;
  logic [2:0]      beat_data;
  logic            beat_tail;

  assign cfg_ok    = (k_len >= KW'(MIN_K)) && (k_len <= KW'(K_MAX)) &&
                     (f1 < k_len) && (f2 < k_len);
  assign start_ok  = start && (state_q == ST_IDLE) && cfg_ok;
  assign load_fire = (state_q == ST_LOAD) && in_valid && in_ready_q;

  // The output register holds one beat; a new beat may be produced when it
  // is empty or being drained this cycle.
  assign out_fire  = out_valid_q && out_ready;
  assign slot_free = !out_valid_q || out_ready;
  assign gen_enc   = (state_q == ST_ENC) && slot_free;
  assign gen_t1    = (state_q == ST_TAIL1) && slot_free;
  assign gen_t2    = (state_q == ST_TAIL2) && slot_free && (cnt_q < KW'(TAIL_LEN));
  assign gen       = gen_enc || gen_t1 || gen_t2;

  // Natural-order and interleaved read ports.
  assign u1 = mem_q[cnt_q[AW-1:0]];
  assign u2 = mem_q[pi_q[AW-1:0]];

  // Register state is only of debug interest at this level.
  assign rsc_state_unused = ^{rsc1_state, rsc2_state};

  turbo_rsc u_rsc1 (
    .clock  (clock),
    .resetb (resetb),
    .clr    (start_ok),
    .en     (gen_enc || gen_t1),
    .term   (state_q == ST_TAIL1),
    .u      (u1),
    .z      (z1),
    .x      (x1),
    .state  (rsc1_state)
  );

  turbo_rsc u_rsc2 (
    .clock  (clock),
    .resetb (resetb),
    .clr    (start_ok),
    .en     (gen_enc || gen_t2),
    .term   (state_q == ST_TAIL2),
    .u      (u2),
    .z      (z2),
    .x      (x2),
    .state  (rsc2_state)
  );

  // Select the beat to be loaded into the output register.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output
    // unassigned, which would otherwise infer a latch.
    beat_data = 3'b000;
    beat_tail = 1'b0;
    case (state_q)
      ST_ENC:   beat_data = {x1, z1, z2};
      ST_TAIL1: begin
        beat_data = {x1, z1, 1'b0};
        beat_tail = 1'b1;
      end
      ST_TAIL2: begin
        beat_data = {x2, z2, 1'b0};
        beat_tail = 1'b1;
      end
      default: ;
    endcase
  end

  // Information-bit buffer, one write port.
  always_ff @(posedge clock) begin
    // NOTE: the buffer is deliberately left out of reset; every bit read in
    // a block is written during LOAD first, and a reset here would turn the
    // array into costly reset flops for no functional gain.
    if (load_fire) begin
      mem_q[cnt_q[AW-1:0]] <= in_bit;
    end
  end

  // Control FSM, interleaver address generator and registered outputs.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      g0_q        <= '0;
      d_q         <= '0;
      pi_q        <= '0;
      g_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 3'b000;
      out_tail_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      if (gen) begin
        out_valid_q <= 1'b1;
        out_data_q  <= beat_data;
        out_tail_q  <= beat_tail;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              k_q        <= k_len;
              g0_q       <= mod_add(f1, f2, k_len);
              d_q        <= mod_add(f2, f2, k_len);
              cnt_q      <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= ST_LOAD;
            end else begin
              cfg_err_q  <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (load_fire) begin
            if (cnt_q == k_q - KW'(1)) begin
              cnt_q      <= '0;
              pi_q       <= '0;
              g_q        <= g0_q;
              in_ready_q <= 1'b0;
              state_q    <= ST_ENC;
            end else begin
              cnt_q <= cnt_q + KW'(1);
            end
          end
        end

        ST_ENC: begin
          if (gen_enc) begin
            pi_q <= mod_add(pi_q, g_q, k_q);
            g_q  <= mod_add(g_q, d_q, k_q);
            if (cnt_q == k_q - KW'(1)) begin
              cnt_q   <= '0;
              state_q <= ST_TAIL1;
            end else begin
              cnt_q <= cnt_q + KW'(1);
            end
          end
        end

        ST_TAIL1: begin
          if (gen_t1) begin
            if (cnt_q == KW'(TAIL_LEN - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_TAIL2;
            end else begin
              cnt_q <= cnt_q + KW'(1);
            end
          end
        end

        ST_TAIL2: begin
          if (gen_t2) begin
            cnt_q <= cnt_q + KW'(1);
          end else if (out_fire && (cnt_q == KW'(TAIL_LEN))) begin
            // Last tail beat has just been taken by the sink.
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tail  = out_tail_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule
